// File: rtl/ram_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// ram_bus_arbiter_pkg
// Shared SoC constants for the system RAM and its bus arbiter.
//   RAM_AW / DW         : RAM address and data widths (4 KiB x 8)
//   RAM_PAGE_NIBBLE     : CPU address bits [15:12] that select the RAM (pages 0x00-0x0F)
//   STARVE_MAX_DEFAULT  : default number of conflict cycles before a DMA steal
// -----------------------------------------------------------------------------
package ram_bus_arbiter_pkg;

   localparam int         RAM_AW             = 12;
   localparam int         DW                 = 8;
   localparam logic [3:0] RAM_PAGE_NIBBLE    = 4'h0;
   localparam int         STARVE_MAX_DEFAULT = 8;

   // Which side drives the RAM port in the current cycle.
   typedef enum logic {
      OWNER_CPU = 1'b0,
      OWNER_DMA = 1'b1
   } port_owner_e;

   // True when a CPU address falls inside the 4 KiB system RAM window.
   function automatic logic is_ram_page(input logic [15:0] ab);
      return (ab[15:12] == RAM_PAGE_NIBBLE);
   endfunction

endpackage

// File: rtl/ram_bus_arbiter.sv
// -----------------------------------------------------------------------------
// ram_bus_arbiter
// Shares the single-port system RAM between the 65xx CPU and one DMA requester.
// The CPU has priority; DMA uses cycles where the CPU is not addressing RAM.
// A DMA request that has waited STARVE_MAX conflicting cycles steals one cycle
// by dropping CPU RDY, during which the DMA access is performed.
//
// Ports
//   CLK1, reset_n         : clock, asynchronous active-low reset
//   cpu_ab/cpu_we_n/cpu_do: CPU address, write enable (low), write data
//   cpu_rdy               : CPU RDY (registered); 0 only during a steal cycle
//   cpu_ram_di            : RAM read data toward the CPU data mux
//   dma_req/we/addr/wdata : DMA request (level) and access description
//   dma_ack               : DMA access performed this cycle
//   dma_rdata/dma_rvalid  : DMA read data, valid the cycle after a read ack
//   ram_addr/we/wdata     : RAM port drive
//   ram_rdata             : RAM read data (synchronous, 1-cycle latency)
//   dma_owner             : debug, DMA owns the RAM port this cycle
// -----------------------------------------------------------------------------
module ram_bus_arbiter #(
   parameter int RAM_AW     = ram_bus_arbiter_pkg::RAM_AW,
   parameter int DW         = ram_bus_arbiter_pkg::DW,
   parameter int STARVE_MAX = ram_bus_arbiter_pkg::STARVE_MAX_DEFAULT
) (
   input  logic              CLK1,
   input  logic              reset_n,
   input  logic [15:0]       cpu_ab,
   input  logic              cpu_we_n,
   input  logic [DW-1:0]     cpu_do,
   output logic              cpu_rdy,
   output logic [DW-1:0]     cpu_ram_di,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [RAM_AW-1:0] dma_addr,
   input  logic [DW-1:0]     dma_wdata,
   output logic              dma_ack,
   output logic [DW-1:0]     dma_rdata,
   output logic              dma_rvalid,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [DW-1:0]     ram_wdata,
   input  logic [DW-1:0]     ram_rdata,
   output logic              dma_owner
);

   import ram_bus_arbiter_pkg::*;

   localparam int            CW        = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX   = CW'(STARVE_MAX);
   localparam logic [CW-1:0] CNT_STEAL = CW'(STARVE_MAX - 1);

   // Slot decision
   logic        cpu_hit;
   logic        dma_slot;
   logic        conflict;
   port_owner_e slot_owner;

   // Starvation tracking
   logic [CW-1:0] starve_cnt_q, starve_cnt_d;
   logic          steal_q,      steal_d;
   logic          cpu_rdy_q,    cpu_rdy_d;

   // Read return
   logic          owner_q,      owner_d;
   logic          dma_rd_q,     dma_rd_d;
   logic          cpu_live_q,   cpu_live_d;
   logic [DW-1:0] dma_rdata_q,  dma_rdata_d;
   logic [DW-1:0] cpu_ram_di_q, cpu_ram_di_d;

   // ---------------------------------------------------------------------------
   // RAM port mux
   // ---------------------------------------------------------------------------
   always_comb begin
      cpu_hit    = is_ram_page(cpu_ab);
      dma_slot   = dma_req & (steal_q | ~cpu_hit);
      conflict   = dma_req & cpu_hit & ~steal_q;
      slot_owner = dma_slot ? OWNER_DMA : OWNER_CPU;

      // A CPU write presented during a steal cycle is suppressed even when the
      // DMA side abandoned its request: the CPU sees RDY=0 and repeats the write
      // on the next cycle, so nothing is lost.
      ram_addr  = cpu_ab[RAM_AW-1:0];
      ram_we    = cpu_hit & ~cpu_we_n & ~steal_q;
      ram_wdata = cpu_do;
      if (slot_owner == OWNER_DMA) begin
         ram_addr  = dma_addr;
         ram_we    = dma_we;
         ram_wdata = dma_wdata;
      end

      dma_ack   = dma_slot;
      dma_owner = dma_slot;
   end

   // ---------------------------------------------------------------------------
   // Starvation counter and steal request
   // ---------------------------------------------------------------------------
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      steal_d      = 1'b0;

      if (!dma_req || dma_slot) begin
         starve_cnt_d = '0;
      end else if (conflict) begin
         if (starve_cnt_q != CNT_MAX) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
         end
         // Steal decided one cycle ahead so RDY can come straight from a flop.
         steal_d = (starve_cnt_q == CNT_STEAL);
      end

      cpu_rdy_d = ~steal_d;
   end

   // ---------------------------------------------------------------------------
   // Read return: RAM data is split toward DMA or CPU by who owned the port on
   // the previous cycle (the RAM has one cycle of read latency).
   // ---------------------------------------------------------------------------
   always_comb begin
      owner_d  = dma_slot;
      dma_rd_d = dma_slot & ~dma_we;
      // cpu_live_q is ~owner_q except that it resets to 0, which keeps
      // cpu_ram_di at its zero hold value while the RAM output is undefined.
      cpu_live_d = ~dma_slot;

      dma_rvalid  = owner_q & dma_rd_q;
      dma_rdata   = dma_rvalid ? ram_rdata : dma_rdata_q;
      dma_rdata_d = dma_rdata;

      // The CPU mux never sees DMA data: hold the last CPU-side value instead.
      cpu_ram_di   = cpu_live_q ? ram_rdata : cpu_ram_di_q;
      cpu_ram_di_d = cpu_ram_di;
   end

   assign cpu_rdy = cpu_rdy_q;

   always_ff @(posedge CLK1 or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt_q <= '0;
         steal_q      <= 1'b0;
         cpu_rdy_q    <= 1'b1;
         owner_q      <= 1'b0;
         dma_rd_q     <= 1'b0;
         cpu_live_q   <= 1'b0;
         dma_rdata_q  <= '0;
         cpu_ram_di_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         steal_q      <= steal_d;
         cpu_rdy_q    <= cpu_rdy_d;
         owner_q      <= owner_d;
         dma_rd_q     <= dma_rd_d;
         cpu_live_q   <= cpu_live_d;
         dma_rdata_q  <= dma_rdata_d;
         cpu_ram_di_q <= cpu_ram_di_d;
      end
   end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_bus_arbiter
// Directed bench for ram_bus_arbiter (STARVE_MAX = 8) with a behavioural
// synchronous RAM. A vector table covers the single-cycle slot decisions and
// read return; hand-written sequences cover starvation, steal/write collision,
// steal spacing, abandoned steals and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_ram_bus_arbiter;

   localparam int SM = 8;

   logic        CLK1 = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] cpu_ab;
   logic        cpu_we_n;
   logic [7:0]  cpu_do;
   logic        cpu_rdy;
   logic [7:0]  cpu_ram_di;
   logic        dma_req;
   logic        dma_we;
   logic [11:0] dma_addr;
   logic [7:0]  dma_wdata;
   logic        dma_ack;
   logic [7:0]  dma_rdata;
   logic        dma_rvalid;
   logic [11:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic        dma_owner;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic mem_clr = 1'b1;
   logic [7:0] mem [0:4095];

   ram_bus_arbiter #(.RAM_AW(12), .DW(8), .STARVE_MAX(SM)) dut (
      .CLK1       (CLK1),
      .reset_n    (reset_n),
      .cpu_ab     (cpu_ab),
      .cpu_we_n   (cpu_we_n),
      .cpu_do     (cpu_do),
      .cpu_rdy    (cpu_rdy),
      .cpu_ram_di (cpu_ram_di),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_ack    (dma_ack),
      .dma_rdata  (dma_rdata),
      .dma_rvalid (dma_rvalid),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .dma_owner  (dma_owner)
   );

   always #5 CLK1 = ~CLK1;

   // Single-port synchronous RAM, read-before-write.
   always @(posedge CLK1) begin
      if (mem_clr) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
         ram_rdata <= 8'h00;
      end else begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         ram_rdata <= mem[ram_addr];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_cpu(input logic [15:0] ab, input logic we_n, input logic [7:0] d);
      cpu_ab = ab; cpu_we_n = we_n; cpu_do = d;
   endtask

   task automatic set_dma(input logic req, input logic we, input logic [11:0] a, input logic [7:0] d);
      dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
   endtask

   task automatic next_cycle();
      @(posedge CLK1); #1;
   endtask

   task automatic sample();
      @(negedge CLK1);
   endtask

   // Returns at the negedge of the ack cycle (or after the bound expires).
   task automatic wait_ack(output int waits, output logic rdy_at_ack);
      waits = 0;
      sample();
      while (dma_ack !== 1'b1 && waits < 40) begin
         waits++;
         next_cycle();
         sample();
      end
      rdy_at_ack = cpu_rdy;
   endtask

   typedef struct {
      logic [15:0] ab;  logic we_n; logic [7:0] cdo;
      logic req;        logic dwe;  logic [11:0] daddr; logic [7:0] dwd;
      logic rdy;        logic ack;  logic we;   logic [11:0] addr; logic rv;
      logic chk_rd;     logic [7:0] rdata;
      logic chk_di;     logic [7:0] di;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int   waits;
      logic rdy_a;
      int   acks;
      int   steals;
      int   run;
      int   max_run;

      // ab, we_n, do | req, we, addr, wdata | rdy, ack, ram_we, ram_addr, rvalid | chk_rd, rdata | chk_di, di
      vecs[0] = '{16'hF000, 1'b1, 8'h00, 1'b1, 1'b1, 12'h123, 8'h5A, 1'b1, 1'b1, 1'b1, 12'h123, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
      vecs[1] = '{16'hF000, 1'b1, 8'h00, 1'b1, 1'b1, 12'h200, 8'h3C, 1'b1, 1'b1, 1'b1, 12'h200, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
      vecs[2] = '{16'hF001, 1'b1, 8'h00, 1'b1, 1'b0, 12'h123, 8'h00, 1'b1, 1'b1, 1'b0, 12'h123, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
      vecs[3] = '{16'h0010, 1'b0, 8'h77, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 12'h010, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h00};
      vecs[4] = '{16'h0010, 1'b1, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 12'h010, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
      vecs[5] = '{16'h0011, 1'b1, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 12'h011, 1'b0, 1'b0, 8'h00, 1'b1, 8'h77};
      vecs[6] = '{16'hF000, 1'b1, 8'h00, 1'b1, 1'b0, 12'h200, 8'h00, 1'b1, 1'b1, 1'b0, 12'h200, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
      vecs[7] = '{16'h0010, 1'b1, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 12'h010, 1'b1, 1'b1, 8'h3C, 1'b1, 8'h00};

      // ---------------- reset state ----------------
      set_cpu(16'hF000, 1'b1, 8'h00);
      set_dma(1'b0, 1'b0, 12'h000, 8'h00);
      repeat (2) @(posedge CLK1);
      sample();
      check("reset_cpu_rdy",    32'(cpu_rdy),    32'd1);
      check("reset_dma_ack",    32'(dma_ack),    32'd0);
      check("reset_dma_rvalid", 32'(dma_rvalid), 32'd0);
      check("reset_dma_rdata",  32'(dma_rdata),  32'd0);
      check("reset_cpu_ram_di", 32'(cpu_ram_di), 32'd0);
      $display("reset: rdy=%0d ack=%0d rvalid=%0d rdata=%h di=%h", cpu_rdy, dma_ack, dma_rvalid, dma_rdata, cpu_ram_di);
      mem_clr = 1'b0;
      reset_n = 1'b1;
      next_cycle();

      // ---------------- vector table ----------------
      for (int v = 0; v < 8; v++) begin
         set_cpu(vecs[v].ab, vecs[v].we_n, vecs[v].cdo);
         set_dma(vecs[v].req, vecs[v].dwe, vecs[v].daddr, vecs[v].dwd);
         sample();
         check($sformatf("vec%0d_rdy", v),       32'(cpu_rdy),    32'(vecs[v].rdy));
         check($sformatf("vec%0d_ack", v),       32'(dma_ack),    32'(vecs[v].ack));
         check($sformatf("vec%0d_owner", v),     32'(dma_owner),  32'(vecs[v].ack));
         check($sformatf("vec%0d_ram_we", v),    32'(ram_we),     32'(vecs[v].we));
         check($sformatf("vec%0d_ram_addr", v),  32'(ram_addr),   32'(vecs[v].addr));
         check($sformatf("vec%0d_rvalid", v),    32'(dma_rvalid), 32'(vecs[v].rv));
         if (vecs[v].chk_rd) check($sformatf("vec%0d_dma_rdata", v), 32'(dma_rdata), 32'(vecs[v].rdata));
         if (vecs[v].chk_di) check($sformatf("vec%0d_cpu_ram_di", v), 32'(cpu_ram_di), 32'(vecs[v].di));
         $display("vec %0d: ab=%h req=%0d rdy=%0d ack=%0d ram_we=%0d ram_addr=%h rvalid=%0d rdata=%h di=%h",
                  v, cpu_ab, dma_req, cpu_rdy, dma_ack, ram_we, ram_addr, dma_rvalid, dma_rdata, cpu_ram_di);
         next_cycle();
      end
      check("mem_123", 32'(mem[12'h123]), 32'h5A);
      check("mem_200", 32'(mem[12'h200]), 32'h3C);
      check("mem_010", 32'(mem[12'h010]), 32'h77);

      // ---------------- starvation: CPU loops on 0x0010, DMA reads 0x200 ----------------
      set_cpu(16'h0010, 1'b1, 8'h00);
      set_dma(1'b1, 1'b0, 12'h200, 8'h00);
      wait_ack(waits, rdy_a);
      check("starve_waits",     32'(waits),    32'(SM));
      check("starve_steal_rdy", 32'(rdy_a),    32'd0);
      check("starve_ram_addr",  32'(ram_addr), 32'h200);
      $display("starve: waits=%0d rdy_at_ack=%0d", waits, rdy_a);
      next_cycle();
      set_dma(1'b0, 1'b0, 12'h000, 8'h00);
      sample();
      check("starve_rvalid", 32'(dma_rvalid), 32'd1);
      check("starve_rdata",  32'(dma_rdata),  32'h3C);
      check("starve_rdy_back", 32'(cpu_rdy),  32'd1);
      next_cycle();
      sample();
      check("starve_cpu_reread", 32'(cpu_ram_di), 32'h77);
      $display("starve return: rdata=%h cpu_di=%h", dma_rdata, cpu_ram_di);
      next_cycle();

      // ---------------- CPU write collides with a steal ----------------
      set_cpu(16'h0010, 1'b1, 8'h00);
      set_dma(1'b1, 1'b1, 12'h041, 8'hC3);
      acks = 0;
      for (int i = 0; i < SM; i++) begin
         sample();
         if (dma_ack === 1'b1) acks++;
         next_cycle();
      end
      check("collide_early_acks", 32'(acks), 32'd0);
      set_cpu(16'h0040, 1'b0, 8'hA5);
      sample();
      check("collide_steal_rdy",  32'(cpu_rdy),   32'd0);
      check("collide_steal_ack",  32'(dma_ack),   32'd1);
      check("collide_steal_addr", 32'(ram_addr),  32'h041);
      check("collide_steal_wd",   32'(ram_wdata), 32'hC3);
      next_cycle();
      set_dma(1'b0, 1'b0, 12'h000, 8'h00);
      sample();
      check("collide_retry_rdy",   32'(cpu_rdy),        32'd1);
      check("collide_retry_we",    32'(ram_we),         32'd1);
      check("collide_retry_addr",  32'(ram_addr),       32'h040);
      check("collide_mem040_pre",  32'(mem[12'h040]),   32'h00);
      check("collide_mem041",      32'(mem[12'h041]),   32'hC3);
      next_cycle();
      set_cpu(16'h0010, 1'b1, 8'h00);
      sample();
      check("collide_mem040_post", 32'(mem[12'h040]), 32'hA5);
      $display("collide: mem040=%h mem041=%h", mem[12'h040], mem[12'h041]);
      next_cycle();

      // ---------------- continuous DMA vs continuous CPU RAM traffic ----------------
      set_dma(1'b1, 1'b0, 12'h200, 8'h00);
      steals = 0; run = 0; max_run = 0;
      for (int i = 0; i < 4 * (SM + 1); i++) begin
         sample();
         check($sformatf("spacing_rdy_c%0d", i), 32'(cpu_rdy), 32'((i % (SM + 1)) != SM));
         if (cpu_rdy === 1'b0) begin
            steals++;
            run++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
         next_cycle();
      end
      check("spacing_steals",  32'(steals),  32'd4);
      check("spacing_max_run", 32'(max_run), 32'd1);
      $display("spacing: steals=%0d max_run=%0d", steals, max_run);
      set_dma(1'b0, 1'b0, 12'h000, 8'h00);
      next_cycle();

      // ---------------- request dropped while steal_q=1 ----------------
      set_dma(1'b1, 1'b1, 12'h050, 8'hEE);
      repeat (SM) next_cycle();
      set_dma(1'b0, 1'b1, 12'h050, 8'hEE);
      set_cpu(16'h0060, 1'b0, 8'h99);
      sample();
      check("drop_rdy",    32'(cpu_rdy),   32'd0);
      check("drop_ack",    32'(dma_ack),   32'd0);
      check("drop_ram_we", 32'(ram_we),    32'd0);
      check("drop_owner",  32'(dma_owner), 32'd0);
      next_cycle();
      sample();
      check("drop_cpu_retry_we", 32'(ram_we), 32'd1);
      next_cycle();
      set_cpu(16'h0010, 1'b1, 8'h00);
      set_dma(1'b1, 1'b0, 12'h050, 8'h00);
      wait_ack(waits, rdy_a);
      check("drop_new_waits", 32'(waits),        32'(SM));
      check("drop_mem050",    32'(mem[12'h050]), 32'h00);
      check("drop_mem060",    32'(mem[12'h060]), 32'h99);
      $display("drop: new waits=%0d mem050=%h mem060=%h", waits, mem[12'h050], mem[12'h060]);
      next_cycle();
      set_dma(1'b0, 1'b0, 12'h000, 8'h00);
      next_cycle();

      // ---------------- reset mid-wait (counter=5) ----------------
      set_dma(1'b1, 1'b0, 12'h200, 8'h00);
      repeat (5) next_cycle();
      #1 reset_n = 1'b0;
      #1 check("midwait_reset_rdy", 32'(cpu_rdy), 32'd1);
      set_dma(1'b0, 1'b0, 12'h000, 8'h00);
      @(posedge CLK1);
      @(negedge CLK1);
      reset_n = 1'b1;
      next_cycle();
      set_dma(1'b1, 1'b0, 12'h200, 8'h00);
      wait_ack(waits, rdy_a);
      check("midwait_new_waits", 32'(waits), 32'(SM));
      check("midwait_steal_rdy", 32'(rdy_a), 32'd0);
      $display("midwait reset: new waits=%0d", waits);

      // ---------------- async reset inside a steal cycle ----------------
      reset_n = 1'b0;
      #1;
      check("steal_reset_rdy",   32'(cpu_rdy),   32'd1);
      check("steal_reset_ack",   32'(dma_ack),   32'd0);
      check("steal_reset_owner", 32'(dma_owner), 32'd0);
      set_dma(1'b0, 1'b0, 12'h000, 8'h00);
      @(posedge CLK1);
      @(negedge CLK1);
      check("steal_reset_rvalid", 32'(dma_rvalid), 32'd0);
      check("steal_reset_rdata",  32'(dma_rdata),  32'd0);
      reset_n = 1'b1;
      next_cycle();
      sample();
      check("post_reset_rdy", 32'(cpu_rdy), 32'd1);
      $display("steal reset: rdy=%0d rvalid=%0d rdata=%h", cpu_rdy, dma_rvalid, dma_rdata);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
